// File: rtl/demux_dispatch_ctrl.sv
// demux_dispatch_ctrl: sequencing controller for a 4-way demultiplexer.
// Takes one word at a time from a valid/ready input, picks a destination
// channel (addressed by in_dest or round-robin), and presents the word on
// exactly one of four valid/ready output channels.
// Optional build macro: DEMUX_TIMEOUT_EN adds a stall counter that discards
// a held word after TIMEOUT cycles without y_ready on its channel.
//
// Handshake semantics: a transfer happens on a rising clk edge where valid
// and ready are both 1. A producer holding valid keeps its data stable until
// that edge; ready may depend combinationally on the consumer side.
// in_ready here is combinational (1 in IDLE, y_ready[sel] in SEND), so a
// delivery and a new accept can share one edge (one word per cycle).
// The FSM has two states and busy is its direct encoding (busy = SEND).

module demux_dispatch_ctrl #(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_dest,
  input  logic             mode,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] Y0,
  output logic [WIDTH-1:0] Y1,
  output logic [WIDTH-1:0] Y2,
  output logic [WIDTH-1:0] Y3,
  output logic [3:0]       y_valid,
  input  logic [3:0]       y_ready,
  output logic             busy,
  output logic             drop
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Reject an unusable stall limit at elaboration time.
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
    $error("demux_dispatch_ctrl: TIMEOUT must be within 1..255");
  end

  state_t                  state_q;
  logic [1:0]              sel_q;
  logic [3:0][WIDTH-1:0]   y_q;
  logic [3:0]              y_valid_q;
  logic [1:0]              rr_ptr_q;
  logic [1:0]              rr_ptr_d;
  logic                    rr_word_q;   // held word was accepted in round-robin mode
  logic                    sel_ready;
  logic                    deliver;
  logic                    discard;
  logic                    accept;
  logic [1:0]              dest_d;

`ifdef DEMUX_TIMEOUT_EN
  localparam logic [8:0] TIMEOUT_C = 9'(TIMEOUT);
  logic [7:0] stall_cnt_q;
  logic       drop_q;
`endif

  // Handshake decode, round-robin pointer advance and destination choice.
  always_comb begin
    sel_ready = y_ready[sel_q];
    deliver   = (state_q == SEND) && sel_ready;
`ifdef DEMUX_TIMEOUT_EN
    // Discard on the edge where the stall count would reach TIMEOUT.
    discard   = (state_q == SEND) && !sel_ready &&
                (({1'b0, stall_cnt_q} + 9'd1) == TIMEOUT_C);
    // No accept in the cycle that reports a drop.
    in_ready  = (state_q == IDLE) ? !drop_q : sel_ready;
`else
    discard   = 1'b0;
    in_ready  = (state_q == IDLE) ? 1'b1 : sel_ready;
`endif
    accept    = in_valid && in_ready;
    // The pointer moves when a round-robin word leaves; a word accepted on
    // the same edge already sees the advanced pointer.
    rr_ptr_d  = rr_ptr_q;
    if ((deliver || discard) && rr_word_q) begin
      rr_ptr_d = rr_ptr_q + 2'd1;
    end
    dest_d    = mode ? rr_ptr_d : in_dest;
  end

  // Main FSM: load on accept, release on delivery or discard, hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sel_q     <= 2'd0;
      y_q       <= '0;
      y_valid_q <= 4'd0;
      rr_ptr_q  <= 2'd0;
      rr_word_q <= 1'b0;
`ifdef DEMUX_TIMEOUT_EN
      stall_cnt_q <= 8'd0;
      drop_q      <= 1'b0;
`endif
    end else begin
      rr_ptr_q <= rr_ptr_d;
`ifdef DEMUX_TIMEOUT_EN
      drop_q   <= 1'b0;
`endif
      if (accept) begin
        // New word: route to one channel, zero the others.
        state_q   <= SEND;
        sel_q     <= dest_d;
        rr_word_q <= mode;
        for (int i = 0; i < 4; i++) begin
          y_q[i]       <= (dest_d == 2'(i)) ? in_data : '0;
          y_valid_q[i] <= (dest_d == 2'(i));
        end
`ifdef DEMUX_TIMEOUT_EN
        stall_cnt_q <= 8'd0;
`endif
      end else if (deliver || discard) begin
        // Word gone (delivered or dropped); sel keeps its last value.
        state_q   <= IDLE;
        y_q       <= '0;
        y_valid_q <= 4'd0;
`ifdef DEMUX_TIMEOUT_EN
        drop_q      <= discard;
        stall_cnt_q <= 8'd0;
`endif
      end
`ifdef DEMUX_TIMEOUT_EN
      else if (state_q == SEND) begin
        stall_cnt_q <= stall_cnt_q + 8'd1;
      end
`endif
    end
  end

  assign sel     = sel_q;
  assign Y0      = y_q[0];
  assign Y1      = y_q[1];
  assign Y2      = y_q[2];
  assign Y3      = y_q[3];
  assign y_valid = y_valid_q;
  assign busy    = (state_q == SEND);
`ifdef DEMUX_TIMEOUT_EN
  assign drop    = drop_q;
`else
  assign drop    = 1'b0;
`endif

endmodule
